// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: register-index width, the zero register,
// default HI/LO latencies and the source-operand match helper.
package pipe_pkg;

    localparam int REG_W           = 5;
    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef logic [REG_W-1:0] reg_idx_t;

    localparam reg_idx_t ZERO_REG = '0;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // The zero register is never a real producer, so it can never match.
    function automatic logic src_match(
        input reg_idx_t prod,
        input reg_idx_t rs,
        input reg_idx_t rt,
        input logic     use_rs,
        input logic     use_rt
    );
        return (prod != ZERO_REG) &&
               ((use_rs && (prod == rs)) || (use_rt && (prod == rt)));
    endfunction

endpackage

// File: rtl/md_busy_timer.sv
// HI/LO unit busy timer: counts down the mult/div latency, flags busy while
// counting and pulses done for one cycle once the count has expired.
module md_busy_timer
    import pipe_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic md_start,
    input  logic md_is_div,
    output logic md_busy,
    output logic md_done
);

    localparam int CNT_MAX = max_int(MULT_CYCLES, DIV_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // A start while still counting is dropped; the running op keeps its timing.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else if (md_start) begin
            cnt_d = md_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end
        busy_d = (cnt_d != '0);
        done_d = (cnt_q == CNT_W'(1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign md_busy = busy_q;
    assign md_done = done_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard detection and stall/flush generation with a HI/LO busy timer.
// Optional stall performance counter enabled by macro HAZARD_PERF_EN.
module hazard_stall_ctrl
    import pipe_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             beq,
    input  logic             jr,
    input  logic [REG_W-1:0] rs_id,
    input  logic [REG_W-1:0] rt_id,
    input  logic             use_rs_id,
    input  logic             use_rt_id,
    input  logic             RegWrite_ex,
    input  logic             MemRead_ex,
    input  logic [REG_W-1:0] a3_ex,
    input  logic             MemRead_mem,
    input  logic [REG_W-1:0] a3_mem,
    input  logic             md_start_ex,
    input  logic             md_is_div_ex,
    input  logic             md_use_id,
    output logic             stall,
    output logic             flush_ex,
    output logic             md_busy,
    output logic             md_done
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]      stall_cnt
`endif
);

    logic match_ex;
    logic match_mem;
    logic branch_id;
    logic load_use_hz;
    logic branch_alu_hz;
    logic branch_load_hz;
    logic md_hz;

    md_busy_timer #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md_busy_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .md_start  (md_start_ex),
        .md_is_div (md_is_div_ex),
        .md_busy   (md_busy),
        .md_done   (md_done)
    );

    // Branches resolve in ID, so they also wait on EX ALU results and MEM loads.
    always_comb begin
        match_ex       = src_match(a3_ex,  rs_id, rt_id, use_rs_id, use_rt_id);
        match_mem      = src_match(a3_mem, rs_id, rt_id, use_rs_id, use_rt_id);
        branch_id      = beq || jr;
        load_use_hz    = MemRead_ex && match_ex;
        branch_alu_hz  = branch_id && RegWrite_ex && match_ex;
        branch_load_hz = branch_id && MemRead_mem && match_mem;
        md_hz          = md_use_id && (md_busy || md_start_ex);
        stall          = load_use_hz || branch_alu_hz || branch_load_hz || md_hz;
        flush_ex       = stall;
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a model.
module tb_hazard_stall_ctrl;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       beq = 1'b0, jr = 1'b0;
    logic [4:0] rs_id = '0, rt_id = '0;
    logic       use_rs_id = 1'b0, use_rt_id = 1'b0;
    logic       RegWrite_ex = 1'b0, MemRead_ex = 1'b0;
    logic [4:0] a3_ex = '0;
    logic       MemRead_mem = 1'b0;
    logic [4:0] a3_mem = '0;
    logic       md_start_ex = 1'b0, md_is_div_ex = 1'b0, md_use_id = 1'b0;
    logic       stall, flush_ex, md_busy, md_done;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    hazard_stall_ctrl #(
        .MULT_CYCLES (MULT_N),
        .DIV_CYCLES  (DIV_N)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .beq          (beq),
        .jr           (jr),
        .rs_id        (rs_id),
        .rt_id        (rt_id),
        .use_rs_id    (use_rs_id),
        .use_rt_id    (use_rt_id),
        .RegWrite_ex  (RegWrite_ex),
        .MemRead_ex   (MemRead_ex),
        .a3_ex        (a3_ex),
        .MemRead_mem  (MemRead_mem),
        .a3_mem       (a3_mem),
        .md_start_ex  (md_start_ex),
        .md_is_div_ex (md_is_div_ex),
        .md_use_id    (md_use_id),
        .stall        (stall),
        .flush_ex     (flush_ex),
        .md_busy      (md_busy),
        .md_done      (md_done)
`ifdef HAZARD_PERF_EN
        ,
        .stall_cnt    (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Model: an op started at cycle S with latency N is busy in cycles S+1..S+N
    // and reports done in cycle S+N+1; reset forgets the op entirely.
    int          cyc       = 0;
    int          start_cyc = -1;
    int          m_len     = 0;
    longint      m_perf    = 0;

    function automatic bit mBusy(input int c);
        return (start_cyc >= 0) && (c > start_cyc) && (c <= start_cyc + m_len);
    endfunction

    function automatic bit mDone(input int c);
        return (start_cyc >= 0) && (c == start_cyc + m_len + 1);
    endfunction

    function automatic bit srcHit(input logic [4:0] p);
        return (p != 5'd0) && ((use_rs_id && p == rs_id) || (use_rt_id && p == rt_id));
    endfunction

    function automatic bit expStall();
        bit br;
        br = beq || jr;
        return (MemRead_ex && srcHit(a3_ex)) ||
               (br && RegWrite_ex && srcHit(a3_ex)) ||
               (br && MemRead_mem && srcHit(a3_mem)) ||
               (md_use_id && (mBusy(cyc) || md_start_ex));
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_cyc = -1;
            m_perf    = 0;
        end else begin
            if (expStall() && m_perf < 64'hFFFF_FFFF) m_perf = m_perf + 1;
            if (md_start_ex && !mBusy(cyc)) begin
                start_cyc = cyc;
                m_len     = md_is_div_ex ? DIV_N : MULT_N;
            end
            cyc = cyc + 1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("[TB] FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        checkOutput("stall",    32'(stall),    32'(expStall()));
        checkOutput("flush_ex", 32'(flush_ex), 32'(expStall()));
        checkOutput("md_busy",  32'(md_busy),  32'(mBusy(cyc)));
        checkOutput("md_done",  32'(md_done),  32'(mDone(cyc)));
`ifdef HAZARD_PERF_EN
        checkOutput("stall_cnt", stall_cnt, m_perf[31:0]);
`endif
    end

    task automatic waitCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        beq = 0; jr = 0; rs_id = 0; rt_id = 0; use_rs_id = 0; use_rt_id = 0;
        RegWrite_ex = 0; MemRead_ex = 0; a3_ex = 0; MemRead_mem = 0; a3_mem = 0;
        md_start_ex = 0; md_is_div_ex = 0; md_use_id = 0;
    endtask

    function automatic logic [4:0] pickReg();
        int r;
        r = $urandom_range(0, 7);
        if (r < 4) return 5'(r);
        if (r == 4) return 5'd31;
        return 5'($urandom_range(0, 31));
    endfunction

    task automatic applyStimulus();
        beq          = ($urandom_range(0, 3) == 0);
        jr           = ($urandom_range(0, 5) == 0);
        rs_id        = pickReg();
        rt_id        = pickReg();
        use_rs_id    = $urandom_range(0, 1) == 1;
        use_rt_id    = $urandom_range(0, 1) == 1;
        RegWrite_ex  = $urandom_range(0, 1) == 1;
        MemRead_ex   = ($urandom_range(0, 2) == 0);
        a3_ex        = pickReg();
        MemRead_mem  = ($urandom_range(0, 2) == 0);
        a3_mem       = pickReg();
        md_start_ex  = ($urandom_range(0, 4) == 0);
        md_is_div_ex = $urandom_range(0, 1) == 1;
        md_use_id    = ($urandom_range(0, 2) == 0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int busy_n, stall_n, done_n, done_at;

        clearInputs();
        #1;
        checkOutput("reset_md_busy", 32'(md_busy), 32'd0);
        checkOutput("reset_md_done", 32'(md_done), 32'd0);
        repeat (3) waitCycle();
        rst_n = 1'b1;
        waitCycle();

        // Load-use
        MemRead_ex = 1; a3_ex = 8; rs_id = 8; use_rs_id = 1;
        #1;
        checkOutput("load_use_stall", 32'(stall), 32'd1);
        checkOutput("load_use_flush", 32'(flush_ex), 32'd1);
        a3_ex = 0; rs_id = 0;
        #1;
        checkOutput("load_use_zero_reg", 32'(stall), 32'd0);
        clearInputs();

        // Branch-ALU
        waitCycle();
        beq = 1; RegWrite_ex = 1; a3_ex = 9; rt_id = 9; use_rt_id = 1;
        #1;
        checkOutput("branch_alu_stall", 32'(stall), 32'd1);
        beq = 0;
        #1;
        checkOutput("branch_alu_nobr", 32'(stall), 32'd0);
        clearInputs();

        // Branch-load
        waitCycle();
        jr = 1; MemRead_mem = 1; a3_mem = 31; rs_id = 31; use_rs_id = 1;
        #1;
        checkOutput("branch_load_stall", 32'(stall), 32'd1);
        use_rs_id = 0;
        #1;
        checkOutput("branch_load_unused", 32'(stall), 32'd0);
        clearInputs();

        // Div timing with md_use_id held high
        waitCycle();
        md_start_ex = 1; md_is_div_ex = 1; md_use_id = 1;
        #2;
        stall_n = stall ? 1 : 0;
        busy_n = 0; done_n = 0; done_at = -1;
        for (int i = 1; i <= 13; i++) begin
            waitCycle();
            md_start_ex = 0; md_is_div_ex = 0;
            #2;
            if (md_busy) busy_n++;
            if (stall) stall_n++;
            if (md_done) begin done_n++; done_at = i; end
        end
        checkOutput("div_busy_cycles", 32'(busy_n), 32'd10);
        checkOutput("div_stall_cycles", 32'(stall_n), 32'd11);
        checkOutput("div_done_count", 32'(done_n), 32'd1);
        checkOutput("div_done_cycle", 32'(done_at), 32'd11);
        clearInputs();

        // Second start while a mult counts down (at count 3) is ignored
        waitCycle();
        md_start_ex = 1;
        busy_n = 0; done_n = 0; done_at = -1;
        for (int i = 1; i <= 12; i++) begin
            waitCycle();
            md_start_ex = (i == 3);
            md_is_div_ex = (i == 3);
            #2;
            if (md_busy) busy_n++;
            if (md_done) begin done_n++; done_at = i; end
        end
        checkOutput("restart_busy_cycles", 32'(busy_n), 32'd5);
        checkOutput("restart_done_count", 32'(done_n), 32'd1);
        checkOutput("restart_done_cycle", 32'(done_at), 32'd6);
        clearInputs();

        // Reset while a div has 4 cycles left
        waitCycle();
        md_start_ex = 1; md_is_div_ex = 1;
        for (int i = 1; i <= 7; i++) begin
            waitCycle();
            md_start_ex = 0; md_is_div_ex = 0;
        end
        checkOutput("pre_reset_busy", 32'(md_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("reset_mid_busy", 32'(md_busy), 32'd0);
`ifdef HAZARD_PERF_EN
        checkOutput("reset_mid_stall_cnt", stall_cnt, 32'd0);
`endif
        waitCycle();
        waitCycle();
        rst_n = 1'b1;
        busy_n = 0; done_n = 0;
        for (int i = 1; i <= 14; i++) begin
            waitCycle();
            #2;
            if (md_busy) busy_n++;
            if (md_done) done_n++;
        end
        checkOutput("reset_no_busy", 32'(busy_n), 32'd0);
        checkOutput("reset_no_done", 32'(done_n), 32'd0);

        // Randomized traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            waitCycle();
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
            applyStimulus();
        end
        waitCycle();
        rst_n = 1'b1;
        clearInputs();
        repeat (3) waitCycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
